// File: rtl/data_mem_ctrl_if.sv
// MEM-stage side of the data memory controller: one request/response bundle.
// The MEM stage drives through master; the controller takes the slave view.
interface data_mem_ctrl_if;
  logic        req_i;
  logic [2:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        exc_o;

  modport master (
    output req_i, op_i, addr_i, wdata_i,
    input  ready_o, done_o, rdata_o, exc_o
  );

  modport slave (
    input  req_i, op_i, addr_i, wdata_i,
    output ready_o, done_o, rdata_o, exc_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data RAM initiator: one load/store at a time, big-endian lane steering,
// load sign/zero extension and a misalignment exception on the registered response.
module data_mem_ctrl #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_ctrl_if.slave    mem_if,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [31:0]       ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  function automatic logic is_store(input logic [2:0] op);
    return op[2] & (op[1] | op[0]);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    logic m;
    case (op)
      3'd2, 3'd3, 3'd6: m = a[0];
      3'd4, 3'd7:       m = (a != 2'b00);
      default:          m = 1'b0;
    endcase
    return m;
  endfunction

  // Byte 0 of a word lives in bits [31:24], so lane selects walk down from bit 3.
  function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] a);
    logic [3:0] s;
    case (op)
      3'd0, 3'd1, 3'd5: s = 4'b1000 >> a;
      3'd2, 3'd3, 3'd6: s = a[1] ? 4'b0011 : 4'b1100;
      default:          s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] w);
    logic [31:0] d;
    case (op)
      3'd5:    d = {4{w[7:0]}};
      3'd6:    d = {2{w[15:0]}};
      3'd7:    d = w;
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = a[1] ? w[15:0] : w[31:16];
    case (op)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {24'd0, b};
      3'd2:    r = {{16{h[15]}}, h};
      3'd3:    r = {16'd0, h};
      3'd4:    r = w;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ce_q, ce_d;
  logic        we_q, we_d;
  logic [31:0] raddr_q, raddr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;

  // Next-state logic; RAM strobes are computed one edge ahead so they leave on flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    lane_d  = lane_q;
    exc_d   = exc_q;
    rdata_d = rdata_q;
    ce_d    = ce_q;
    we_d    = we_q;
    raddr_d = raddr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_if.req_i) begin
          op_d   = mem_if.op_i;
          lane_d = mem_if.addr_i[1:0];
          if (misaligned(mem_if.op_i, mem_if.addr_i[1:0])) begin
            state_d = S_RESP;
            exc_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = 4'(WAIT_CYCLES);
            ce_d    = 1'b1;
            we_d    = is_store(mem_if.op_i);
            raddr_d = {mem_if.addr_i[31:2], 2'b00};
            sel_d   = lane_sel(mem_if.op_i, mem_if.addr_i[1:0]);
            wdata_d = store_data(mem_if.op_i, mem_if.wdata_i);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          exc_d   = 1'b0;
          if (!is_store(op_q)) begin
            rdata_d = load_extract(op_q, lane_q, ram_data_i);
          end else begin
            rdata_d = rdata_q;
          end
          ce_d    = 1'b0;
          we_d    = 1'b0;
          raddr_d = 32'd0;
          sel_d   = 4'd0;
          wdata_d = 32'd0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        ce_d    = 1'b0;
        we_d    = 1'b0;
        raddr_d = 32'd0;
        sel_d   = 4'd0;
        wdata_d = 32'd0;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_RESP);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      lane_q  <= 2'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
      rdata_q <= 32'd0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      raddr_q <= 32'd0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      rdata_q <= rdata_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      raddr_q <= raddr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_if.ready_o = ready_q;
  assign mem_if.done_o  = done_q;
  assign mem_if.rdata_o = rdata_q;
  assign mem_if.exc_o   = exc_q;
  assign ram_ce_o       = ce_q;
  assign ram_we_o       = we_q;
  assign ram_addr_o     = raddr_q;
  assign ram_sel_o      = sel_q;
  assign ram_data_o     = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a zero-wait instance driven from a vector table and a
// three-wait instance exercising hold-off, back-to-back issue and mid-access reset.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst3_n;
  logic        ce0, we0, ce3, we3;
  logic [31:0] addr0, wd0, rd0, addr3, wd3, rd3;
  logic [3:0]  sel0, sel3;
  logic [31:0] mem0 [16];
  logic [31:0] mem3 [16];

  data_mem_ctrl_if if0();
  data_mem_ctrl_if if3();

  data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .mem_if(if0.slave),
    .ram_ce_o(ce0), .ram_we_o(we0), .ram_addr_o(addr0), .ram_sel_o(sel0),
    .ram_data_o(wd0), .ram_data_i(rd0)
  );

  data_mem_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .mem_if(if3.slave),
    .ram_ce_o(ce3), .ram_we_o(we3), .ram_addr_o(addr3), .ram_sel_o(sel3),
    .ram_data_o(wd3), .ram_data_i(rd3)
  );

  // Simple RAMs: combinational read, lane-masked write on the clock edge.
  assign rd0 = mem0[addr0[5:2]];
  assign rd3 = mem3[addr3[5:2]];

  always @(posedge clk) begin
    if (!rst0_n) begin
      for (int k = 0; k < 16; k++) mem0[k] <= 32'd0;
    end else if (ce0 && we0) begin
      for (int l = 0; l < 4; l++)
        if (sel0[l]) mem0[addr0[5:2]][l*8 +: 8] <= wd0[l*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (!rst3_n) begin
      for (int k = 0; k < 16; k++) mem3[k] <= 32'd0;
      mem3[8] <= 32'hCAFEF00D;
    end else if (ce3 && we3) begin
      for (int l = 0; l < 4; l++)
        if (sel3[l]) mem3[addr3[5:2]][l*8 +: 8] <= wd3[l*8 +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_exc;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int done_seen;
    logic st;

    //          op    addr          wdata          rdata          exc   sel      ram data
    vecs[0]  = '{3'd7, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF};
    vecs[1]  = '{3'd4, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0};
    vecs[2]  = '{3'd0, 32'h11, 32'h0,        32'hFFFFFFAD, 1'b0, 4'b0100, 32'h0};
    vecs[3]  = '{3'd0, 32'h12, 32'h0,        32'hFFFFFFBE, 1'b0, 4'b0010, 32'h0};
    vecs[4]  = '{3'd0, 32'h13, 32'h0,        32'hFFFFFFEF, 1'b0, 4'b0001, 32'h0};
    vecs[5]  = '{3'd1, 32'h10, 32'h0,        32'h000000DE, 1'b0, 4'b1000, 32'h0};
    vecs[6]  = '{3'd2, 32'h12, 32'h0,        32'hFFFFBEEF, 1'b0, 4'b0011, 32'h0};
    vecs[7]  = '{3'd3, 32'h10, 32'h0,        32'h0000DEAD, 1'b0, 4'b1100, 32'h0};
    vecs[8]  = '{3'd5, 32'h13, 32'h00000055, 32'h0,        1'b0, 4'b0001, 32'h55555555};
    vecs[9]  = '{3'd4, 32'h10, 32'h0,        32'hDEADBE55, 1'b0, 4'b1111, 32'h0};
    vecs[10] = '{3'd4, 32'h12, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[11] = '{3'd6, 32'h11, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[12] = '{3'd6, 32'h16, 32'h12348001, 32'h0,        1'b0, 4'b0011, 32'h80018001};
    vecs[13] = '{3'd2, 32'h16, 32'h0,        32'hFFFF8001, 1'b0, 4'b0011, 32'h0};
    vecs[14] = '{3'd1, 32'h14, 32'h0,        32'h00000000, 1'b0, 4'b1000, 32'h0};
    vecs[15] = '{3'd4, 32'h14, 32'h0,        32'h00008001, 1'b0, 4'b1111, 32'h0};
    vecs[16] = '{3'd2, 32'h13, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[17] = '{3'd0, 32'h12, 32'h0,        32'hFFFFFFBE, 1'b0, 4'b0010, 32'h0};

    rst0_n = 1'b0;
    rst3_n = 1'b0;
    if0.req_i = 1'b0; if0.op_i = 3'd0; if0.addr_i = 32'd0; if0.wdata_i = 32'd0;
    if3.req_i = 1'b0; if3.op_i = 3'd0; if3.addr_i = 32'd0; if3.wdata_i = 32'd0;

    repeat (2) @(negedge clk);
    check("rst ready", {31'd0, if0.ready_o}, 32'd1);
    check("rst done",  {31'd0, if0.done_o},  32'd0);
    check("rst exc",   {31'd0, if0.exc_o},   32'd0);
    check("rst rdata", if0.rdata_o, 32'd0);
    check("rst ram",   {ce0, we0, sel0, 26'd0} | addr0 | wd0, 32'd0);
    check("rst ce3",   {31'd0, ce3}, 32'd0);
    rst0_n = 1'b1;
    rst3_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      st = vecs[i].op[2] & (vecs[i].op[1] | vecs[i].op[0]);
      check($sformatf("v%0d ready", i), {31'd0, if0.ready_o}, 32'd1);
      if0.req_i  = 1'b1;
      if0.op_i   = vecs[i].op;
      if0.addr_i = vecs[i].addr;
      if0.wdata_i = vecs[i].wdata;
      @(negedge clk);
      if0.req_i = 1'b0;
      if (vecs[i].exp_exc) begin
        check($sformatf("v%0d ce", i),   {31'd0, ce0}, 32'd0);
        check($sformatf("v%0d done", i), {31'd0, if0.done_o}, 32'd1);
        check($sformatf("v%0d exc", i),  {31'd0, if0.exc_o}, 32'd1);
      end else begin
        check($sformatf("v%0d ce", i),   {31'd0, ce0}, 32'd1);
        check($sformatf("v%0d we", i),   {31'd0, we0}, {31'd0, st});
        check($sformatf("v%0d addr", i), addr0, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("v%0d sel", i),  {28'd0, sel0}, {28'd0, vecs[i].exp_sel});
        check($sformatf("v%0d early done", i), {31'd0, if0.done_o}, 32'd0);
        if (st) check($sformatf("v%0d wdata", i), wd0, vecs[i].exp_wd);
        @(negedge clk);
        check($sformatf("v%0d done", i), {31'd0, if0.done_o}, 32'd1);
        check($sformatf("v%0d exc", i),  {31'd0, if0.exc_o}, 32'd0);
        check($sformatf("v%0d ce off", i), {ce0, we0, sel0, 26'd0} | addr0 | wd0, 32'd0);
        if (!st) check($sformatf("v%0d rdata", i), if0.rdata_o, vecs[i].exp_rdata);
      end
      @(negedge clk);
      check($sformatf("v%0d done pulse", i), {31'd0, if0.done_o}, 32'd0);
      check($sformatf("v%0d ce idle", i),    {31'd0, ce0}, 32'd0);
    end

    // Three wait cycles with req_i held high across successive accesses.
    @(negedge clk);
    check("w3 ready", {31'd0, if3.ready_o}, 32'd1);
    if3.req_i = 1'b1; if3.op_i = 3'd4; if3.addr_i = 32'h20;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("w3a ce c%0d", c),    {31'd0, ce3}, 32'd1);
      check($sformatf("w3a done c%0d", c),  {31'd0, if3.done_o}, 32'd0);
      check($sformatf("w3a ready c%0d", c), {31'd0, if3.ready_o}, 32'd0);
    end
    @(negedge clk);
    check("w3a done",  {31'd0, if3.done_o}, 32'd1);
    check("w3a rdata", if3.rdata_o, 32'hCAFEF00D);
    check("w3a ce",    {31'd0, ce3}, 32'd0);
    check("w3a ready", {31'd0, if3.ready_o}, 32'd0);
    if3.op_i = 3'd1; if3.addr_i = 32'h21;
    @(negedge clk);
    check("w3 idle ready", {31'd0, if3.ready_o}, 32'd1);
    check("w3 idle ce",    {31'd0, ce3}, 32'd0);
    check("w3 idle done",  {31'd0, if3.done_o}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("w3b ce c%0d", c),   {31'd0, ce3}, 32'd1);
      check($sformatf("w3b done c%0d", c), {31'd0, if3.done_o}, 32'd0);
    end
    @(negedge clk);
    check("w3b done",  {31'd0, if3.done_o}, 32'd1);
    check("w3b rdata", if3.rdata_o, 32'h000000FE);
    if3.op_i = 3'd4; if3.addr_i = 32'h20;
    @(negedge clk);
    check("w3c ready", {31'd0, if3.ready_o}, 32'd1);
    @(negedge clk);
    check("w3c ce c1", {31'd0, ce3}, 32'd1);
    @(negedge clk);
    check("w3c ce c2", {31'd0, ce3}, 32'd1);
    rst3_n = 1'b0;
    if3.req_i = 1'b0;
    #1;
    check("w3c ce after rst", {31'd0, ce3}, 32'd0);
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (if3.done_o) done_seen++;
    end
    check("w3c no done", done_seen, 32'd0);
    rst3_n = 1'b1;
    @(negedge clk);
    check("w3c ready after rst", {31'd0, if3.ready_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
